// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings, FSM states
// and the default operand width.
package mdu_pkg;

    localparam int MDU_W = 32;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } mdu_state_e;

    function automatic logic op_is_signed(mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

    function automatic logic op_is_div(mdu_op_e op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_hilo_if.sv
// EX-stage request bus into the MDU and the HI/LO commit/bypass bus back out.
interface mdu_hilo_if #(parameter int W = mdu_pkg::MDU_W) ();

    logic         start_i;
    logic [2:0]   op_i;
    logic [W-1:0] srca_i;
    logic [W-1:0] srcb_i;
    logic         flush_i;
    logic         busy_o;
    logic         hi_we_o;
    logic [W-1:0] hi_wdata_o;
    logic         lo_we_o;
    logic [W-1:0] lo_wdata_o;
    logic [W-1:0] hi_q_o;
    logic [W-1:0] lo_q_o;

    modport master (
        output start_i, op_i, srca_i, srcb_i, flush_i,
        input  busy_o, hi_we_o, hi_wdata_o, lo_we_o, lo_wdata_o, hi_q_o, lo_q_o
    );

    modport slave (
        input  start_i, op_i, srca_i, srcb_i, flush_i,
        output busy_o, hi_we_o, hi_wdata_o, lo_we_o, lo_wdata_o, hi_q_o, lo_q_o
    );

endinterface

// File: rtl/mdu_iter_core.sv
// Iterative datapath: radix-2 shift-add multiply or restoring divide on unsigned
// operands, one step per cycle, W steps per operation.
module mdu_iter_core #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         step_i,
    input  logic         div_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         done_o,
    output logic [W-1:0] hi_o,
    output logic [W-1:0] lo_o
);

    localparam int CW = $clog2(W);

    // acc_q holds {partial product} for MUL, {remainder, dividend/quotient} for DIV
    logic [2*W-1:0] acc_q, acc_d;
    logic [W-1:0]   opb_q;
    logic           div_q;
    logic [CW-1:0]  cnt_q;

    logic [W:0]     add_sum;
    logic [W:0]     div_shift;
    logic [W:0]     div_diff;
    logic           div_ge;
    logic           unused_borrow;

    always_comb begin
        add_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        div_ge    = (div_shift >= {1'b0, opb_q});
        if (div_q) begin
            acc_d = {(div_ge ? div_diff[W-1:0] : div_shift[W-1:0]), acc_q[W-2:0], div_ge};
        end else begin
            acc_d = {add_sum, acc_q[W-1:1]};
        end
    end

    // Top bit of the difference is meaningless once the compare has chosen the branch
    assign unused_borrow = div_diff[W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
            opb_q <= '0;
            div_q <= 1'b0;
            cnt_q <= '0;
        end else if (load_i) begin
            acc_q <= {{W{1'b0}}, a_i};
            opb_q <= b_i;
            div_q <= div_i;
            cnt_q <= '0;
        end else if (step_i) begin
            acc_q <= acc_d;
            cnt_q <= CW'(cnt_q + 1'b1);
        end
    end

    assign done_o = (cnt_q == CW'(W - 1));
    assign hi_o   = acc_q[2*W-1:W];
    assign lo_o   = acc_q[W-1:0];

endmodule

// File: rtl/mdu_hilo.sv
// Multiply/divide unit with architectural HI/LO registers and one-cycle write strobes
// feeding the decode-stage HI/LO bypass.
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int W = MDU_W
) (
    input  logic      clk,
    input  logic      rst_n,
    mdu_hilo_if.slave bus
);

    mdu_state_e   state_q, state_d;
    logic [W-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [W-1:0] hi_wdata_q, hi_wdata_d, lo_wdata_q, lo_wdata_d;
    logic         hi_we_q, hi_we_d, lo_we_q, lo_we_d;
    logic         is_div_q, is_div_d;
    logic         neg_res_q, neg_res_d;
    logic         neg_rem_q, neg_rem_d;

    logic         core_load, core_step, core_done;
    logic [W-1:0] core_hi, core_lo;
    logic [W-1:0] abs_a, abs_b;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0] quo_fix, rem_fix;
    mdu_op_e      op;
    logic         op_signed;

    assign op        = mdu_op_e'(bus.op_i);
    assign op_signed = op_is_signed(op);
    assign abs_a     = (op_signed && bus.srca_i[W-1]) ? -bus.srca_i : bus.srca_i;
    assign abs_b     = (op_signed && bus.srcb_i[W-1]) ? -bus.srcb_i : bus.srcb_i;

    // Remainder takes the dividend's sign; quotient/product negate when operand signs differ
    assign prod_fix = neg_res_q ? -{core_hi, core_lo} : {core_hi, core_lo};
    assign quo_fix  = neg_res_q ? -core_lo : core_lo;
    assign rem_fix  = neg_rem_q ? -core_hi : core_hi;

    mdu_iter_core #(.W(W)) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (core_load),
        .step_i (core_step),
        .div_i  (op_is_div(op)),
        .a_i    (abs_a),
        .b_i    (abs_b),
        .done_o (core_done),
        .hi_o   (core_hi),
        .lo_o   (core_lo)
    );

    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        hi_wdata_d = hi_wdata_q;
        lo_wdata_d = lo_wdata_q;
        hi_we_d    = 1'b0;
        lo_we_d    = 1'b0;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        core_load  = 1'b0;
        core_step  = 1'b0;

        if (bus.flush_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start_i) begin
                        case (op)
                            MDU_MTHI: begin
                                hi_d       = bus.srca_i;
                                hi_wdata_d = bus.srca_i;
                                hi_we_d    = 1'b1;
                            end
                            MDU_MTLO: begin
                                lo_d       = bus.srca_i;
                                lo_wdata_d = bus.srca_i;
                                lo_we_d    = 1'b1;
                            end
                            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                                core_load = 1'b1;
                                is_div_d  = op_is_div(op);
                                neg_res_d = op_signed & (bus.srca_i[W-1] ^ bus.srcb_i[W-1]);
                                neg_rem_d = op_signed & bus.srca_i[W-1];
                                state_d   = S_RUN;
                            end
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    core_step = 1'b1;
                    if (core_done) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*W-1:W];
                        lo_d = prod_fix[W-1:0];
                    end
                    hi_wdata_d = hi_d;
                    lo_wdata_d = lo_d;
                    hi_we_d    = 1'b1;
                    lo_we_d    = 1'b1;
                    state_d    = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            hi_q       <= '0;
            lo_q       <= '0;
            hi_wdata_q <= '0;
            lo_wdata_q <= '0;
            hi_we_q    <= 1'b0;
            lo_we_q    <= 1'b0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            hi_wdata_q <= hi_wdata_d;
            lo_wdata_q <= lo_wdata_d;
            hi_we_q    <= hi_we_d;
            lo_we_q    <= lo_we_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
        end
    end

    assign bus.busy_o     = (state_q != S_IDLE);
    assign bus.hi_we_o    = hi_we_q;
    assign bus.lo_we_o    = lo_we_q;
    assign bus.hi_wdata_o = hi_wdata_q;
    assign bus.lo_wdata_o = lo_wdata_q;
    assign bus.hi_q_o     = hi_q;
    assign bus.lo_q_o     = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: expected HI/LO results are queued when an op is
// issued and popped when the commit strobe appears.
module tb_mdu_hilo;
    import mdu_pkg::*;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    always #5 clk = ~clk;

    mdu_hilo_if #(.W(32)) bus ();

    mdu_hilo #(.W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    function automatic res_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        res_t r;
        longint sa, sb, q, rm;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = '0;
        case (op)
            MDU_MULT: begin
                p = 64'(sa * sb);
                r = {p[63:32], p[31:0]};
            end
            MDU_MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                r = {p[63:32], p[31:0]};
            end
            MDU_DIV: begin
                if (b == 32'd0) begin
                    r.hi = a;
                    r.lo = a[31] ? 32'd1 : 32'hFFFF_FFFF;
                end else begin
                    q  = sa / sb;
                    rm = sa % sb;
                    r.hi = rm[31:0];
                    r.lo = q[31:0];
                end
            end
            MDU_DIVU: begin
                if (b == 32'd0) begin
                    r.hi = a;
                    r.lo = 32'hFFFF_FFFF;
                end else begin
                    r.hi = a % b;
                    r.lo = a / b;
                end
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic drive_start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.srca_i  = a;
        bus.srcb_i  = b;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
    endtask

    task automatic wait_commit(output int busy_cnt, output bit seen);
        busy_cnt = 0;
        seen     = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.hi_we_o || bus.lo_we_o) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy_o) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.busy_o, bus.hi_we_o, bus.lo_we_o, bus.hi_q_o, bus.lo_q_o, bus.hi_wdata_o, bus.lo_wdata_o} !== '0) begin
            errors++;
            $display("FAIL reset_state got busy=%b hi_we=%b lo_we=%b hi=%h lo=%h hwd=%h lwd=%h exp all zero",
                     bus.busy_o, bus.hi_we_o, bus.lo_we_o, bus.hi_q_o, bus.lo_q_o, bus.hi_wdata_o, bus.lo_wdata_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.busy_o, bus.hi_we_o, bus.lo_we_o, bus.hi_q_o, bus.lo_q_o} !== '0) begin
            errors++;
            $display("FAIL reset_release got busy=%b hi=%h lo=%h exp 0", bus.busy_o, bus.hi_q_o, bus.lo_q_o);
        end
        $display("txn reset done");
    endtask

    task automatic test_mthi_mtlo();
        res_t e;
        // MTHI
        exp_q.push_back({32'h1234_5678, lo_m});
        drive_start(MDU_MTHI, 32'h1234_5678, 32'h0);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (bus.hi_we_o !== 1'b1 || bus.lo_we_o !== 1'b0 || bus.busy_o !== 1'b0 ||
            bus.hi_q_o !== e.hi || bus.hi_wdata_o !== e.hi || bus.lo_q_o !== e.lo) begin
            errors++;
            $display("FAIL mthi got we=%b/%b busy=%b hi=%h hwd=%h lo=%h exp we=1/0 busy=0 hi=%h lo=%h",
                     bus.hi_we_o, bus.lo_we_o, bus.busy_o, bus.hi_q_o, bus.hi_wdata_o, bus.lo_q_o, e.hi, e.lo);
        end
        hi_m = e.hi;
        $display("txn MTHI a=12345678 hi=%h lo=%h", bus.hi_q_o, bus.lo_q_o);
        @(negedge clk);
        checks++;
        if (bus.hi_we_o !== 1'b0) begin
            errors++;
            $display("FAIL mthi_pulse got hi_we=%b exp 0", bus.hi_we_o);
        end
        // MTLO
        exp_q.push_back({hi_m, 32'hCAFE_0001});
        drive_start(MDU_MTLO, 32'hCAFE_0001, 32'h0);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (bus.lo_we_o !== 1'b1 || bus.hi_we_o !== 1'b0 || bus.busy_o !== 1'b0 ||
            bus.lo_q_o !== e.lo || bus.lo_wdata_o !== e.lo || bus.hi_q_o !== e.hi) begin
            errors++;
            $display("FAIL mtlo got we=%b/%b busy=%b hi=%h lo=%h lwd=%h exp hi=%h lo=%h",
                     bus.hi_we_o, bus.lo_we_o, bus.busy_o, bus.hi_q_o, bus.lo_q_o, bus.lo_wdata_o, e.hi, e.lo);
        end
        lo_m = e.lo;
        $display("txn MTLO a=cafe0001 hi=%h lo=%h", bus.hi_q_o, bus.lo_q_o);
        // flush in IDLE suppresses a same-cycle MTLO
        bus.flush_i = 1'b1;
        drive_start(MDU_MTLO, 32'h5555_AAAA, 32'h0);
        bus.flush_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.lo_we_o !== 1'b0 || bus.lo_q_o !== lo_m) begin
            errors++;
            $display("FAIL idle_flush got lo_we=%b lo=%h exp lo_we=0 lo=%h", bus.lo_we_o, bus.lo_q_o, lo_m);
        end
        $display("txn MTLO+flush lo=%h", bus.lo_q_o);
    endtask

    task automatic test_arith(input string name, input logic [2:0] op_t[8], input logic [31:0] a_t[8],
                              input logic [31:0] b_t[8], input res_t d_t[8], input int n_dir);
        res_t e;
        int   bc;
        bit   seen;
        for (int i = 0; i < 8; i++) begin
            if (i < n_dir) e = d_t[i];
            else           e = model(op_t[i], a_t[i], b_t[i]);
            exp_q.push_back(e);
            drive_start(op_t[i], a_t[i], b_t[i]);
            wait_commit(bc, seen);
            e = exp_q.pop_front();
            checks++;
            if (!seen) begin
                errors++;
                $display("FAIL %s_timeout[%0d] got no strobe exp strobe", name, i);
            end else begin
                checks++;
                if (bus.hi_q_o !== e.hi || bus.lo_q_o !== e.lo) begin
                    errors++;
                    $display("FAIL %s_result[%0d] op=%0d a=%h b=%h got hi=%h lo=%h exp hi=%h lo=%h",
                             name, i, op_t[i], a_t[i], b_t[i], bus.hi_q_o, bus.lo_q_o, e.hi, e.lo);
                end
                checks++;
                if (bus.hi_we_o !== 1'b1 || bus.lo_we_o !== 1'b1 || bus.hi_wdata_o !== e.hi ||
                    bus.lo_wdata_o !== e.lo || bus.busy_o !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_strobe[%0d] got we=%b/%b wd=%h/%h busy=%b exp we=1/1 wd=%h/%h busy=0",
                             name, i, bus.hi_we_o, bus.lo_we_o, bus.hi_wdata_o, bus.lo_wdata_o, bus.busy_o, e.hi, e.lo);
                end
                checks++;
                if (bc != 33) begin
                    errors++;
                    $display("FAIL %s_busy_len[%0d] got %0d exp 33", name, i, bc);
                end
                $display("txn %s op=%0d a=%h b=%h hi=%h lo=%h busy=%0d", name, op_t[i], a_t[i], b_t[i],
                         bus.hi_q_o, bus.lo_q_o, bc);
                @(negedge clk);
                checks++;
                if (bus.hi_we_o !== 1'b0 || bus.lo_we_o !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_pulse[%0d] got we=%b/%b exp 0/0", name, i, bus.hi_we_o, bus.lo_we_o);
                end
            end
            hi_m = e.hi;
            lo_m = e.lo;
        end
    endtask

    task automatic test_mul();
        logic [2:0]  op_t[8];
        logic [31:0] a_t[8], b_t[8];
        res_t        d_t[8];
        op_t[0] = MDU_MULT;  a_t[0] = 32'hFFFF_FFFD; b_t[0] = 32'd7;         d_t[0] = {32'hFFFF_FFFF, 32'hFFFF_FFEB};
        op_t[1] = MDU_MULTU; a_t[1] = 32'hFFFF_FFFF; b_t[1] = 32'hFFFF_FFFF; d_t[1] = {32'hFFFF_FFFE, 32'h0000_0001};
        op_t[2] = MDU_MULT;  a_t[2] = 32'h8000_0000; b_t[2] = 32'h8000_0000; d_t[2] = {32'h4000_0000, 32'h0};
        op_t[3] = MDU_MULTU; a_t[3] = 32'h0;         b_t[3] = 32'h1234_5678; d_t[3] = {32'h0, 32'h0};
        for (int i = 4; i < 8; i++) begin
            op_t[i] = (i % 2 == 0) ? MDU_MULT : MDU_MULTU;
            a_t[i]  = $urandom;
            b_t[i]  = $urandom;
            d_t[i]  = '0;
        end
        test_arith("mul", op_t, a_t, b_t, d_t, 4);
    endtask

    task automatic test_div();
        logic [2:0]  op_t[8];
        logic [31:0] a_t[8], b_t[8];
        res_t        d_t[8];
        op_t[0] = MDU_DIV;  a_t[0] = 32'hFFFF_FFF9; b_t[0] = 32'd2;         d_t[0] = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
        op_t[1] = MDU_DIVU; a_t[1] = 32'd100;       b_t[1] = 32'd0;         d_t[1] = {32'd100, 32'hFFFF_FFFF};
        op_t[2] = MDU_DIV;  a_t[2] = 32'h8000_0000; b_t[2] = 32'hFFFF_FFFF; d_t[2] = {32'h0, 32'h8000_0000};
        op_t[3] = MDU_DIVU; a_t[3] = 32'd100;       b_t[3] = 32'd7;         d_t[3] = {32'd2, 32'd14};
        op_t[4] = MDU_DIV;  a_t[4] = 32'd7;         b_t[4] = 32'hFFFF_FFFE; d_t[4] = {32'd1, 32'hFFFF_FFFD};
        for (int i = 5; i < 8; i++) begin
            op_t[i] = (i % 2 == 0) ? MDU_DIV : MDU_DIVU;
            a_t[i]  = $urandom;
            b_t[i]  = (i == 7) ? 32'($urandom_range(1, 255)) : $urandom;
            d_t[i]  = '0;
        end
        test_arith("div", op_t, a_t, b_t, d_t, 5);
    endtask

    task automatic test_flush();
        res_t e;
        int   strobes = 0;
        int   bc;
        bit   seen;
        drive_start(MDU_DIVU, 32'd1000, 32'd7);
        repeat (9) @(negedge clk);
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle got busy=%b exp 0", bus.busy_o);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.hi_we_o || bus.lo_we_o) strobes++;
        end
        checks++;
        if (strobes != 0 || bus.hi_q_o !== hi_m || bus.lo_q_o !== lo_m) begin
            errors++;
            $display("FAIL flush_nowrite got strobes=%0d hi=%h lo=%h exp strobes=0 hi=%h lo=%h",
                     strobes, bus.hi_q_o, bus.lo_q_o, hi_m, lo_m);
        end
        $display("txn DIVU+flush hi=%h lo=%h", bus.hi_q_o, bus.lo_q_o);
        exp_q.push_back({32'd0, 32'd42});
        drive_start(MDU_MULTU, 32'd6, 32'd7);
        wait_commit(bc, seen);
        e = exp_q.pop_front();
        checks++;
        if (!seen || bus.hi_q_o !== e.hi || bus.lo_q_o !== e.lo) begin
            errors++;
            $display("FAIL after_flush seen=%b got hi=%h lo=%h exp hi=%h lo=%h", seen, bus.hi_q_o, bus.lo_q_o, e.hi, e.lo);
        end
        hi_m = e.hi;
        lo_m = e.lo;
        $display("txn MULTU 6*7 hi=%h lo=%h", bus.hi_q_o, bus.lo_q_o);
        @(negedge clk);
    endtask

    task automatic test_busy_ignore();
        res_t e;
        int   bc;
        int   strobes = 0;
        bit   seen;
        exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFD3});
        drive_start(MDU_MULT, 32'd5, 32'hFFFF_FFF7);
        bus.op_i    = MDU_MTHI;
        bus.srca_i  = 32'hDEAD_BEEF;
        bus.start_i = 1'b1;
        repeat (5) @(negedge clk);
        bus.start_i = 1'b0;
        wait_commit(bc, seen);
        e = exp_q.pop_front();
        checks++;
        if (!seen || bus.hi_q_o !== e.hi || bus.lo_q_o !== e.lo) begin
            errors++;
            $display("FAIL busy_ignore seen=%b got hi=%h lo=%h exp hi=%h lo=%h", seen, bus.hi_q_o, bus.lo_q_o, e.hi, e.lo);
        end
        hi_m = e.hi;
        lo_m = e.lo;
        $display("txn MULT 5*-9 (start during busy) hi=%h lo=%h", bus.hi_q_o, bus.lo_q_o);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.hi_we_o || bus.lo_we_o) strobes++;
        end
        checks++;
        if (strobes != 0 || bus.hi_q_o !== hi_m) begin
            errors++;
            $display("FAIL busy_ignore_extra got strobes=%0d hi=%h exp strobes=0 hi=%h", strobes, bus.hi_q_o, hi_m);
        end
    endtask

    task automatic test_reset_midrun();
        int strobes = 0;
        drive_start(MDU_MULTU, 32'd1234, 32'd5678);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.hi_q_o !== 32'h0 || bus.lo_q_o !== 32'h0 || bus.busy_o !== 1'b0 ||
            bus.hi_we_o !== 1'b0 || bus.lo_we_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_midrun got hi=%h lo=%h busy=%b we=%b/%b exp all 0",
                     bus.hi_q_o, bus.lo_q_o, bus.busy_o, bus.hi_we_o, bus.lo_we_o);
        end
        rst_n = 1'b1;
        hi_m  = '0;
        lo_m  = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.hi_we_o || bus.lo_we_o || bus.busy_o) strobes++;
        end
        checks++;
        if (strobes != 0 || bus.hi_q_o !== hi_m || bus.lo_q_o !== lo_m) begin
            errors++;
            $display("FAIL reset_midrun_quiet got activity=%0d hi=%h lo=%h exp 0", strobes, bus.hi_q_o, bus.lo_q_o);
        end
        $display("txn reset mid-run hi=%h lo=%h", bus.hi_q_o, bus.lo_q_o);
    endtask

    initial begin
        bus.start_i = 1'b0;
        bus.op_i    = 3'd0;
        bus.srca_i  = '0;
        bus.srcb_i  = '0;
        bus.flush_i = 1'b0;
        @(negedge clk);
        test_reset();
        test_mthi_mtlo();
        test_mul();
        test_div();
        test_flush();
        test_busy_ignore();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
